// File: rtl/secded_mem_engine.sv
// Memory-walking Hamming SECDED (16,11) encode/decode engine on a byte-wide data-memory port.
// Optional build macro SECDED_ERR_CNT_EN enables the single/double error counters.
module secded_mem_engine #(
   parameter int NUM_MSGS = 15,
   parameter int SRC_BASE = 0,
   parameter int DST_BASE = 30,
   parameter int ADDR_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              mode,
   output logic              done,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [7:0]        mem_rdata,
   output logic              mem_wr_en,
   output logic [7:0]        mem_wdata,
   output logic [7:0]        err_single_cnt,
   output logic [7:0]        err_double_cnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_LO, S_RD_HI, S_CAP, S_WR_LO, S_WR_HI, S_DONE
   } state_t;

   localparam logic [6:0] LAST_IDX = 7'(NUM_MSGS - 1);

   state_t            state, state_nx;
   logic [6:0]        idx;
   logic              mode_q;
   logic [7:0]        lo_q;
   logic [15:0]       res_q;
   logic              accept;
   logic [ADDR_W-1:0] off, src_lo, dst_lo;
   logic [10:0]       din;
   logic [15:0]       enc, cw, corr, dec;
   logic [3:0]        syn;
   logic              par, is_single, is_double;

   assign accept = req && (state == S_IDLE || state == S_DONE);
   assign off    = ADDR_W'({idx, 1'b0});
   assign src_lo = ADDR_W'(SRC_BASE) + off;
   assign dst_lo = ADDR_W'(DST_BASE) + off;

   // Result is computed from the captured low byte and the high byte arriving in CAP.
   always_comb begin
      din = {mem_rdata[2:0], lo_q};
      enc = '0;
      enc[15:9] = din[10:4];
      enc[7:5]  = din[3:1];
      enc[3]    = din[0];
      enc[1] = ^{enc[3], enc[5], enc[7], enc[9], enc[11], enc[13], enc[15]};
      enc[2] = ^{enc[3], enc[6], enc[7], enc[10], enc[11], enc[14], enc[15]};
      enc[4] = ^{enc[7:5], enc[15:12]};
      enc[8] = ^enc[15:9];
      enc[0] = ^enc[15:1];

      cw     = {mem_rdata, lo_q};
      syn[0] = ^{cw[1], cw[3], cw[5], cw[7], cw[9], cw[11], cw[13], cw[15]};
      syn[1] = ^{cw[2], cw[3], cw[6], cw[7], cw[10], cw[11], cw[14], cw[15]};
      syn[2] = ^{cw[7:4], cw[15:12]};
      syn[3] = ^cw[15:8];
      par    = ^cw;
      is_single = par;
      is_double = !par && (syn != 4'd0);
      corr = cw;
      if (par && syn != 4'd0) corr[syn] = ~corr[syn];
      dec = {is_double, is_single, 3'b000, corr[15:9], corr[7:5], corr[3]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      mem_addr  = '0;
      mem_rd_en = 1'b0;
      mem_wr_en = 1'b0;
      mem_wdata = '0;
      done      = 1'b0;
      busy      = 1'b0;
      case (state)
         S_IDLE:  if (accept) state_nx = S_RD_LO;
         S_RD_LO: begin
            busy = 1'b1; mem_rd_en = 1'b1; mem_addr = src_lo;
            state_nx = S_RD_HI;
         end
         S_RD_HI: begin
            busy = 1'b1; mem_rd_en = 1'b1; mem_addr = src_lo + ADDR_W'(1);
            state_nx = S_CAP;
         end
         S_CAP: begin
            busy = 1'b1;
            state_nx = S_WR_LO;
         end
         S_WR_LO: begin
            busy = 1'b1; mem_wr_en = 1'b1; mem_addr = dst_lo; mem_wdata = res_q[7:0];
            state_nx = S_WR_HI;
         end
         S_WR_HI: begin
            busy = 1'b1; mem_wr_en = 1'b1; mem_addr = dst_lo + ADDR_W'(1);
            mem_wdata = res_q[15:8];
            state_nx = (idx == LAST_IDX) ? S_DONE : S_RD_LO;
         end
         S_DONE: begin
            done = 1'b1;
            if (accept) state_nx = S_RD_LO;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx    <= '0;
         mode_q <= 1'b0;
         lo_q   <= '0;
         res_q  <= '0;
      end else if (accept) begin
         idx    <= '0;
         mode_q <= mode;
      end else begin
         case (state)
            S_RD_HI: lo_q  <= mem_rdata;
            S_CAP:   res_q <= mode_q ? dec : enc;
            S_WR_HI: if (idx != LAST_IDX) idx <= idx + 7'd1;
            default: ;
         endcase
      end
   end

`ifdef SECDED_ERR_CNT_EN
   logic [7:0] single_q, double_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         single_q <= '0;
         double_q <= '0;
      end else if (accept) begin
         single_q <= '0;
         double_q <= '0;
      end else if (state == S_CAP && mode_q) begin
         if (is_single && single_q != 8'hFF) single_q <= single_q + 8'd1;
         if (is_double && double_q != 8'hFF) double_q <= double_q + 8'd1;
      end
   end

   assign err_single_cnt = single_q;
   assign err_double_cnt = double_q;
`else
   assign err_single_cnt = '0;
   assign err_double_cnt = '0;
`endif

endmodule
